layer_step_scheduler: RTL and testbench

Top-level sequencer for the neuroset layer pipeline. It drives the `step` number consumed by the RAM-to-memory loader and the convolution/dense compute engine. It issues one start pulse per step and waits for the matching completion pulse before advancing. A per-step watchdog detects a hung engine. Step encoding:
- step 1: pixel load.
- step 2k: weight load for layer k.
- step 2k+1 (k ≥ 1): compute of layer k.

---
 rtl/layer_step_scheduler.sv | 152 +++++++++++++++
 tb/tb_layer_step_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_step_scheduler.sv
// Step sequencer for the layer pipeline: pixel load, then weight load / compute per layer.
// Issues one start pulse per step, waits for the matching done pulse, and guards each step with a watchdog.
module layer_step_scheduler #(
    parameter int NUM_LAYERS = 7,
    parameter int STEP_W     = 5,
    parameter int TMR_W      = 16,
    parameter int TIMEOUT    = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              load_done,
    input  logic              conv_done,
    output logic [STEP_W-1:0] step,
    output logic [3:0]        layer,
    output logic              nextstep,
    output logic              load_start,
    output logic              conv_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2 * NUM_LAYERS + 1);
    localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [3:0]        layer_q, layer_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              nextstep_q, nextstep_d;
    logic              load_start_q, load_start_d;
    logic              conv_start_q, conv_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic is_load;
    logic exp_done;
    logic last_step;
    logic timeout_hit;

    function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] t);
        return (t == '1) ? t : t + 1'b1;
    endfunction

    // Step 1 and even steps are loads; odd steps from 3 are compute.
    assign is_load     = (step_q == STEP_W'(1)) || !step_q[0];
    assign exp_done    = is_load ? load_done : conv_done;
    assign last_step   = (step_q == LAST_STEP);
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            step_q       <= '0;
            layer_q      <= '0;
            timer_q      <= '0;
            nextstep_q   <= 1'b0;
            load_start_q <= 1'b0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            layer_q      <= layer_d;
            timer_q      <= timer_d;
            nextstep_q   <= nextstep_d;
            load_start_q <= load_start_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go) state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                // A completion in the expiry cycle takes priority over the watchdog.
                if (exp_done)         state_d = last_step ? S_FINISH : S_ISSUE;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  if (go) state_d = S_ISSUE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d       = step_q;
        timer_d      = timer_q;
        nextstep_d   = 1'b0;
        load_start_d = 1'b0;
        conv_start_d = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        busy_d       = (state_d == S_ISSUE) || (state_d == S_WAIT);
        case (state_q)
            S_IDLE: if (go) step_d = STEP_W'(1);
            S_ISSUE: begin
                timer_d      = '0;
                load_start_d = is_load;
                conv_start_d = !is_load;
            end
            S_WAIT: begin
                timer_d = sat_inc(timer_q);
                if (exp_done && !last_step) begin
                    step_d     = step_q + 1'b1;
                    nextstep_d = 1'b1;
                end else if (!exp_done && timeout_hit) begin
                    err_d = 1'b1;
                end
            end
            S_FINISH: begin
                done_d = 1'b1;
                step_d = '0;
            end
            S_ERROR: begin
                if (go) begin
                    err_d  = 1'b0;
                    step_d = STEP_W'(1);
                end
            end
            default: ;
        endcase
        layer_d = 4'(step_d >> 1);
    end

    assign step       = step_q;
    assign layer      = layer_q;
    assign nextstep   = nextstep_q;
    assign load_start = load_start_q;
    assign conv_start = conv_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_layer_step_scheduler.sv
// Bench for layer_step_scheduler: three instances (normal, short watchdog, watchdog disabled)
// share stimulus; each scenario task checks the instance it targets.
module tb_layer_step_scheduler;

    localparam int NL   = 2;
    localparam int LAST = 2 * NL + 1;

    logic clk = 1'b0;
    logic rst, go, load_done, conv_done;

    logic [4:0] a_step, b_step, c_step;
    logic [3:0] a_layer, b_layer, c_layer;
    logic a_nextstep, a_load_start, a_conv_start, a_busy, a_done, a_err;
    logic b_nextstep, b_load_start, b_conv_start, b_busy, b_done, b_err;
    logic c_nextstep, c_load_start, c_conv_start, c_busy, c_done, c_err;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    layer_step_scheduler #(.NUM_LAYERS(NL), .STEP_W(5), .TMR_W(16), .TIMEOUT(100)) u_a (
        .clk(clk), .rst(rst), .go(go), .load_done(load_done), .conv_done(conv_done),
        .step(a_step), .layer(a_layer), .nextstep(a_nextstep), .load_start(a_load_start),
        .conv_start(a_conv_start), .busy(a_busy), .done(a_done), .err(a_err));

    layer_step_scheduler #(.NUM_LAYERS(NL), .STEP_W(5), .TMR_W(16), .TIMEOUT(10)) u_b (
        .clk(clk), .rst(rst), .go(go), .load_done(load_done), .conv_done(conv_done),
        .step(b_step), .layer(b_layer), .nextstep(b_nextstep), .load_start(b_load_start),
        .conv_start(b_conv_start), .busy(b_busy), .done(b_done), .err(b_err));

    layer_step_scheduler #(.NUM_LAYERS(NL), .STEP_W(5), .TMR_W(16), .TIMEOUT(0)) u_c (
        .clk(clk), .rst(rst), .go(go), .load_done(load_done), .conv_done(conv_done),
        .step(c_step), .layer(c_layer), .nextstep(c_nextstep), .load_start(c_load_start),
        .conv_start(c_conv_start), .busy(c_busy), .done(c_done), .err(c_err));

    function automatic bit model_is_load(input int s);
        return (s == 1) || (s % 2 == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; go = 1'b0; load_done = 1'b0; conv_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_load();
        load_done = 1'b1; tick(); load_done = 1'b0;
    endtask

    task automatic pulse_conv();
        conv_done = 1'b1; tick(); conv_done = 1'b0;
    endtask

    task automatic start_run();
        go = 1'b1; tick(); go = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; go = 1'b0; load_done = 1'b0; conv_done = 1'b0;
        #2;
        total++;
        if ({a_step, a_layer, a_nextstep, a_load_start, a_conv_start, a_busy, a_done, a_err} !== 15'd0)
            $display("FAIL reset_a: got %h want 0", {a_step, a_layer, a_nextstep, a_load_start, a_conv_start, a_busy, a_done, a_err});
        else passed++;
        total++;
        if ({b_step, b_layer, b_nextstep, b_load_start, b_conv_start, b_busy, b_done, b_err} !== 15'd0)
            $display("FAIL reset_b: got %h want 0", {b_step, b_layer, b_nextstep, b_load_start, b_conv_start, b_busy, b_done, b_err});
        else passed++;
        total++;
        if ({c_step, c_layer, c_nextstep, c_load_start, c_conv_start, c_busy, c_done, c_err} !== 15'd0)
            $display("FAIL reset_c: got %h want 0", {c_step, c_layer, c_nextstep, c_load_start, c_conv_start, c_busy, c_done, c_err});
        else passed++;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_run();
        int seq = 0, ls = 0, cs = 0, ns = 0, dn = 0, er = 0;
        int exp_seq = 0, exp_ls = 0, exp_cs = 0;
        int prev = 0, lcnt = 0, ccnt = 0;
        bit fin = 1'b0;
        for (int s = 1; s <= LAST; s++) begin
            exp_seq = exp_seq * 10 + s;
            if (model_is_load(s)) exp_ls = exp_ls * 10 + s;
            else                  exp_cs = exp_cs * 10 + s;
        end
        exp_seq = exp_seq * 10;
        apply_reset();
        start_run();
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (int'(a_step) != prev) seq = seq * 10 + int'(a_step);
            prev = int'(a_step);
            if (a_load_start) begin ls = ls * 10 + int'(a_step); lcnt = 5; end
            if (a_conv_start) begin cs = cs * 10 + int'(a_step); ccnt = 5; end
            ns += int'(a_nextstep);
            dn += int'(a_done);
            er |= int'(a_err);
            if (a_done) fin = 1'b1;
            load_done = 1'b0; conv_done = 1'b0;
            if (lcnt > 0) begin lcnt--; if (lcnt == 0) load_done = 1'b1; end
            if (ccnt > 0) begin ccnt--; if (ccnt == 0) conv_done = 1'b1; end
            tick();
        end
        load_done = 1'b0; conv_done = 1'b0;
        total++; if (fin !== 1'b1) $display("FAIL full_run_finished: got %0d want 1", fin); else passed++;
        total++; if (seq !== exp_seq) $display("FAIL full_run_steps: got %0d want %0d", seq, exp_seq); else passed++;
        total++; if (ls !== exp_ls) $display("FAIL full_run_load_starts: got %0d want %0d", ls, exp_ls); else passed++;
        total++; if (cs !== exp_cs) $display("FAIL full_run_conv_starts: got %0d want %0d", cs, exp_cs); else passed++;
        total++; if (ns !== LAST - 1) $display("FAIL full_run_nextsteps: got %0d want %0d", ns, LAST - 1); else passed++;
        total++; if (dn !== 1) $display("FAIL full_run_done_pulses: got %0d want 1", dn); else passed++;
        total++; if (er !== 0) $display("FAIL full_run_err: got %0d want 0", er); else passed++;
    endtask

    task automatic test_wrong_done();
        int ns = 0, cs = 0;
        apply_reset();
        start_run();
        tick();
        pulse_load();
        tick();
        conv_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(); conv_done = 1'b0;
            ns += int'(a_nextstep);
        end
        total++; if (a_step !== 5'd2) $display("FAIL wrong_done_step: got %0d want 2", a_step); else passed++;
        total++; if (ns !== 0) $display("FAIL wrong_done_nextstep: got %0d want 0", ns); else passed++;
        pulse_load();
        total++; if ({a_step, a_nextstep} !== {5'd3, 1'b1})
            $display("FAIL wrong_done_advance: got step %0d nextstep %0d want 3 1", a_step, a_nextstep); else passed++;
        for (int i = 0; i < 4; i++) begin tick(); cs += int'(a_conv_start); end
        total++; if (cs !== 1) $display("FAIL wrong_done_conv_start: got %0d want 1", cs); else passed++;
    endtask

    task automatic test_watchdog();
        apply_reset();
        start_run();
        tick();
        repeat (9) tick();
        total++; if (b_err !== 1'b0) $display("FAIL watchdog_early: got %0d want 0", b_err); else passed++;
        tick();
        total++; if ({b_err, b_step, b_busy} !== {1'b1, 5'd1, 1'b0})
            $display("FAIL watchdog_fire: got err %0d step %0d busy %0d want 1 1 0", b_err, b_step, b_busy); else passed++;
        repeat (3) tick();
        total++; if ({b_err, b_step} !== {1'b1, 5'd1})
            $display("FAIL watchdog_sticky: got err %0d step %0d want 1 1", b_err, b_step); else passed++;
        start_run();
        total++; if ({b_err, b_step, b_busy} !== {1'b0, 5'd1, 1'b1})
            $display("FAIL watchdog_restart: got err %0d step %0d busy %0d want 0 1 1", b_err, b_step, b_busy); else passed++;
        tick();
        total++; if (b_load_start !== 1'b1) $display("FAIL watchdog_restart_load: got %0d want 1", b_load_start); else passed++;
    endtask

    task automatic test_go_while_busy();
        int ls = 0, ns = 0;
        apply_reset();
        start_run();
        tick();
        pulse_load();
        tick();
        pulse_load();
        conv_done = 1'b1; go = 1'b1;
        tick();
        conv_done = 1'b0;
        total++; if ({a_step, a_conv_start} !== {5'd3, 1'b1})
            $display("FAIL busy_issue: got step %0d conv_start %0d want 3 1", a_step, a_conv_start); else passed++;
        for (int i = 0; i < 5; i++) begin
            tick();
            ls += int'(a_load_start);
            ns += int'(a_nextstep);
        end
        go = 1'b0;
        total++; if ({a_step, a_busy} !== {5'd3, 1'b1})
            $display("FAIL busy_go_ignored: got step %0d busy %0d want 3 1", a_step, a_busy); else passed++;
        total++; if (ls + ns !== 0) $display("FAIL busy_no_pulses: got %0d want 0", ls + ns); else passed++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        start_run();
        tick();
        pulse_load();
        tick();
        pulse_load();
        tick();
        pulse_conv();
        tick();
        total++; if ({a_step, a_busy} !== {5'd4, 1'b1})
            $display("FAIL async_pre: got step %0d busy %0d want 4 1", a_step, a_busy); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if ({a_step, a_layer, a_busy, a_err} !== 11'd0)
            $display("FAIL async_clear: got step %0d layer %0d busy %0d err %0d want 0", a_step, a_layer, a_busy, a_err); else passed++;
        rst = 1'b0;
        tick();
        start_run();
        total++; if ({a_step, a_busy} !== {5'd1, 1'b1})
            $display("FAIL async_restart: got step %0d busy %0d want 1 1", a_step, a_busy); else passed++;
        tick();
        total++; if (a_load_start !== 1'b1) $display("FAIL async_restart_load: got %0d want 1", a_load_start); else passed++;
    endtask

    task automatic test_no_timeout();
        apply_reset();
        start_run();
        repeat (70000) tick();
        total++; if ({c_err, c_busy, c_step} !== {1'b0, 1'b1, 5'd1})
            $display("FAIL notimeout_hold: got err %0d busy %0d step %0d want 0 1 1", c_err, c_busy, c_step); else passed++;
        pulse_load();
        total++; if ({c_step, c_nextstep} !== {5'd2, 1'b1})
            $display("FAIL notimeout_late_done: got step %0d nextstep %0d want 2 1", c_step, c_nextstep); else passed++;
    endtask

    task automatic test_random();
        for (int run = 0; run < 3; run++) begin
            int s = 1;
            bit fin = 1'b0;
            apply_reset();
            start_run();
            while (!fin) begin
                int lat = 0, ns = 0, d;
                bit ld = model_is_load(s);
                while (!(a_load_start || a_conv_start) && lat < 8) begin tick(); lat++; end
                total++; if (lat !== 1) $display("FAIL rand_start_latency: got %0d want 1", lat); else passed++;
                total++; if ({a_step, a_layer, a_load_start, a_conv_start} !== {5'(s), 4'(s / 2), ld, !ld})
                    $display("FAIL rand_start: got step %0d layer %0d ls %0d cs %0d want %0d %0d %0d %0d",
                             a_step, a_layer, a_load_start, a_conv_start, s, s / 2, ld, !ld); else passed++;
                d = int'($urandom_range(1, 30));
                for (int i = 0; i < d; i++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        if (ld) conv_done = 1'b1; else load_done = 1'b1;
                    end
                    tick();
                    load_done = 1'b0; conv_done = 1'b0;
                    ns += int'(a_nextstep);
                end
                total++; if ({a_step, 8'(ns)} !== {5'(s), 8'd0})
                    $display("FAIL rand_hold: got step %0d nextsteps %0d want %0d 0", a_step, ns, s); else passed++;
                if (ld) pulse_load(); else pulse_conv();
                if (s < LAST) begin
                    total++; if ({a_step, a_nextstep} !== {5'(s + 1), 1'b1})
                        $display("FAIL rand_advance: got step %0d nextstep %0d want %0d 1", a_step, a_nextstep, s + 1); else passed++;
                    s++;
                end else begin
                    tick();
                    total++; if ({a_done, a_step} !== {1'b1, 5'd0})
                        $display("FAIL rand_done: got done %0d step %0d want 1 0", a_done, a_step); else passed++;
                    tick();
                    total++; if ({a_done, a_busy, a_step, a_err} !== 8'd0)
                        $display("FAIL rand_idle: got done %0d busy %0d step %0d err %0d want 0", a_done, a_busy, a_step, a_err); else passed++;
                    fin = 1'b1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_wrong_done();
        test_watchdog();
        test_go_while_busy();
        test_async_reset();
        test_random();
        test_no_timeout();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
